// File: rtl/axil_seq_reader.sv
// AXI4-Lite sequential burst reader: issues one read at a time from a start
// address and streams the returned words out through a small FIFO.
module axil_seq_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [2:0]            m_axi_arprot,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            remain_q, remain_d;
  logic                  err_q, err_d;
  logic                  zeroDone_q, zeroDone_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wrPtr_q, rdPtr_q;
  logic [CntW-1:0]       fifoCnt_q;

  logic push;
  logic pop;
  logic slotFree;
  logic burstDone;

  assign out_valid = (fifoCnt_q != '0);
  assign pop       = out_valid && out_ready;
  // A pop in this cycle frees a slot in time for the beat this read will return.
  assign slotFree  = (fifoCnt_q != CntW'(FIFO_DEPTH)) || pop;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    err_d         = err_q;
    zeroDone_d    = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    push          = 1'b0;
    burstDone     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (word_count != 8'd0) begin
            addr_d   = start_addr & ~ADDR_WIDTH'(3);
            remain_d = word_count;
            state_d  = ADDR;
          end else begin
            zeroDone_d = 1'b1;
          end
        end
      end
      ADDR: begin
        m_axi_arvalid = slotFree;
        if (slotFree && m_axi_arready) begin
          addr_d  = addr_q + ADDR_WIDTH'(4);
          state_d = DATA;
        end
      end
      DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          push     = 1'b1;
          remain_d = remain_q - 8'd1;
          if (m_axi_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (remain_q == 8'd1) begin
            burstDone = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      err_q      <= 1'b0;
      zeroDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      err_q      <= err_d;
      zeroDone_q <= zeroDone_d;
    end
  end

  // Storage needs no reset; emptiness is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= m_axi_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PtrW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   fifoCnt_q <= fifoCnt_q + CntW'(1);
        2'b01:   fifoCnt_q <= fifoCnt_q - CntW'(1);
        default: fifoCnt_q <= fifoCnt_q;
      endcase
    end
  end

  assign out_data     = mem_q[rdPtr_q];
  assign busy         = (state_q != IDLE);
  assign done         = zeroDone_q || burstDone;
  assign err          = err_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_arprot = 3'b000;

endmodule

// File: tb/tb_axil_seq_reader.sv
// Directed bench for axil_seq_reader with a 1-cycle AXI-Lite slave model and
// a scoreboard of expected addresses and output words.
module tb_axil_seq_reader;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [7:0]    word_count;
  logic          busy, done, err;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid, m_axi_arready;
  logic [2:0]    m_axi_arprot;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;

  axil_seq_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_arprot(m_axi_arprot),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] expAddrQ[$];
  logic [DW-1:0] expDataQ[$];
  int arHsCount = 0;
  int doneCount = 0;
  int errBeat   = -1;
  int slaveBeat = 0;
  logic          arFire, rFire;
  logic [AW-1:0] arSeen;

  function automatic logic [DW-1:0] dataFor(input logic [AW-1:0] a);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushBurst(input logic [AW-1:0] sa, input int n);
    logic [AW-1:0] a;
    a = sa & ~AW'(3);
    slaveBeat = 0;
    for (int i = 0; i < n; i++) begin
      expAddrQ.push_back(a);
      expDataQ.push_back(dataFor(a));
      a = a + AW'(4);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] sa, input logic [7:0] n);
    start_addr = sa;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "DoneSeen"}, 64'(seen), 64'd1);
    tick();
  endtask

  // Slave: decisions taken at negedge reflect the handshakes of the next posedge.
  initial begin
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      arFire = m_axi_arvalid && m_axi_arready && rstn;
      rFire  = m_axi_rvalid && m_axi_rready && rstn;
      arSeen = m_axi_araddr;
      if (arFire) begin
        arHsCount++;
        if (expAddrQ.size() == 0) checkOutput("arUnexpected", 64'd1, 64'd0);
        else checkOutput("araddr", 64'(arSeen), 64'(expAddrQ.pop_front()));
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_axi_rvalid = 1'b0;
      end else begin
        if (rFire) m_axi_rvalid = 1'b0;
        if (arFire) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = dataFor(arSeen);
          m_axi_rresp  = (slaveBeat == errBeat) ? 2'b10 : 2'b00;
          slaveBeat++;
        end
      end
    end
  end

  // Output scoreboard and done-pulse counter.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expDataQ.size() == 0) checkOutput("outUnexpected", 64'd1, 64'd0);
        else checkOutput("outData", 64'(out_data), 64'(expDataQ.pop_front()));
      end
      if (done) doneCount++;
    end
  end

  int d0, a0;
  bit found;

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstArvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("rstRready", 64'(m_axi_rready), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstErr", 64'(err), 64'd0);
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstAraddr", 64'(m_axi_araddr), 64'd0);
    checkOutput("arprot", 64'(m_axi_arprot), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Basic three-word burst with a free-running consumer.
    out_ready = 1'b1;
    d0 = doneCount;
    pushBurst(13'h010, 3);
    applyStimulus(13'h010, 8'd3);
    @(negedge clk);
    checkOutput("t1Busy", 64'(busy), 64'd1);
    checkOutput("t1ArvalidN1", 64'(m_axi_arvalid), 64'd1);
    waitDone(40, "t1");
    tick(3);
    checkOutput("t1DoneOnce", 64'(doneCount - d0), 64'd1);
    checkOutput("t1Err", 64'(err), 64'd0);
    checkOutput("t1Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);

    // Stalled consumer: the FIFO fills and the reader waits.
    out_ready = 1'b0;
    a0 = arHsCount;
    d0 = doneCount;
    pushBurst(13'h100, 6);
    applyStimulus(13'h100, 8'd6);
    tick(30);
    @(negedge clk);
    checkOutput("t2ArCount4", 64'(arHsCount - a0), 64'd4);
    checkOutput("t2ArvalidLow", 64'(m_axi_arvalid), 64'd0);
    checkOutput("t2OutValid", 64'(out_valid), 64'd1);
    checkOutput("t2Head", 64'(out_data), 64'(dataFor(13'h100)));
    tick();
    out_ready = 1'b1;
    waitDone(60, "t2");
    tick(4);
    checkOutput("t2ArCount6", 64'(arHsCount - a0), 64'd6);
    checkOutput("t2DoneOnce", 64'(doneCount - d0), 64'd1);
    checkOutput("t2Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);

    // Address wrap at the top of the 13-bit space; low bits ignored.
    pushBurst(13'h1FFE, 2);
    applyStimulus(13'h1FFE, 8'd2);
    waitDone(40, "t3");
    tick(3);
    checkOutput("t3Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);

    // Error response on the second beat; sticky until the next start.
    errBeat = 1;
    d0 = doneCount;
    pushBurst(13'h040, 3);
    applyStimulus(13'h040, 8'd3);
    waitDone(40, "t4");
    @(negedge clk);
    checkOutput("t4ErrSet", 64'(err), 64'd1);
    tick(3);
    checkOutput("t4ErrSticky", 64'(err), 64'd1);
    checkOutput("t4DoneOnce", 64'(doneCount - d0), 64'd1);
    checkOutput("t4Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);
    errBeat = -1;
    pushBurst(13'h080, 1);
    applyStimulus(13'h080, 8'd1);
    @(negedge clk);
    checkOutput("t4ErrCleared", 64'(err), 64'd0);
    tick();
    waitDone(40, "t4b");
    tick(3);

    // Zero-length request, then a start pulsed mid-burst.
    a0 = arHsCount;
    d0 = doneCount;
    applyStimulus(13'h200, 8'd0);
    @(negedge clk);
    checkOutput("t5ZeroDone", 64'(done), 64'd1);
    checkOutput("t5ZeroBusy", 64'(busy), 64'd0);
    checkOutput("t5ZeroArvalid", 64'(m_axi_arvalid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t5ZeroDoneEnds", 64'(done), 64'd0);
    checkOutput("t5ZeroNoAr", 64'(arHsCount - a0), 64'd0);
    tick();
    d0 = doneCount;
    pushBurst(13'h300, 4);
    applyStimulus(13'h300, 8'd4);
    tick();
    start_addr = 13'h700;
    word_count = 8'd9;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    waitDone(40, "t5");
    tick(6);
    checkOutput("t5IgnoredDone", 64'(doneCount - d0), 64'd1);
    checkOutput("t5IgnoredAr", 64'(arHsCount - a0), 64'd4);
    checkOutput("t5IdleAfter", 64'(busy), 64'd0);
    checkOutput("t5Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);

    // Reset asserted while a read is in its data phase.
    out_ready = 1'b0;
    a0 = arHsCount;
    d0 = doneCount;
    pushBurst(13'h400, 5);
    applyStimulus(13'h400, 8'd5);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if ((arHsCount - a0) >= 3 && m_axi_rready) found = 1'b1;
    end
    checkOutput("t6ReachedData", 64'(found), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("t6Arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("t6Rready", 64'(m_axi_rready), 64'd0);
    checkOutput("t6Busy", 64'(busy), 64'd0);
    checkOutput("t6Done", 64'(done), 64'd0);
    checkOutput("t6OutValid", 64'(out_valid), 64'd0);
    checkOutput("t6Araddr", 64'(m_axi_araddr), 64'd0);
    expAddrQ.delete();
    expDataQ.delete();
    tick(2);
    rstn = 1'b1;
    tick();
    checkOutput("t6NoDone", 64'(doneCount - d0), 64'd0);
    checkOutput("t6FifoEmpty", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    pushBurst(13'h020, 2);
    applyStimulus(13'h020, 8'd2);
    waitDone(40, "t6");
    tick(4);
    checkOutput("t6Drained", 64'(expDataQ.size() + expAddrQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_seq_reader.md
AXIL_SEQ_READER -- requirements
Module: axil_seq_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, byte-address width of the AXI4-Lite read channel.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data and output stream width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a burst of sequential reads.
REQ-008 start_addr  input  ADDR_WIDTH  byte address of the first word; bits [1:0] are ignored and treated as 0.
REQ-009 word_count  input  8  number of words to read (0..255).
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the burst completes.
REQ-012 err  output  1  sticky flag: some rresp != 2'b00 in the current or last burst.
REQ-013 m_axi_araddr  output  ADDR_WIDTH  read address.
REQ-014 m_axi_arvalid  output  1  read address valid.
REQ-015 m_axi_arready  input  1  read address ready.
REQ-016 m_axi_arprot  output  3  constant 3'b000.
REQ-017 m_axi_rdata  input  DATA_WIDTH  read data.
REQ-018 m_axi_rresp  input  2  read response.
REQ-019 m_axi_rvalid  input  1  read data valid.
REQ-020 m_axi_rready  output  1  read data ready.
REQ-021 out_data  output  DATA_WIDTH  head-of-FIFO word.
REQ-022 out_valid  output  1  FIFO non-empty.
REQ-023 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Function
REQ-024 SHALL implement states IDLE, ADDR, DATA; at most one AXI read outstanding.
REQ-025 IDLE: start=1 with word_count>0 SHALL latch the address (low two bits cleared) and the count, clear err, and go to ADDR next cycle.
REQ-026 IDLE: start=1 with word_count=0 SHALL pulse done in the next cycle without any AXI activity, and SHALL clear err.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 ADDR: arvalid SHALL be high only while the FIFO has at least one free slot, counting the current-cycle pop; araddr = current address.
REQ-029 After arvalid is asserted, araddr SHALL stay stable and arvalid SHALL stay high until arready=1.
REQ-030 On the AR handshake the block SHALL go to DATA and advance the address by 4, modulo 2^ADDR_WIDTH.
REQ-031 DATA: rready SHALL be 1, because a slot was reserved in ADDR.
REQ-032 On an R handshake the block SHALL push rdata into the FIFO and decrement the remaining count.
REQ-033 On an R handshake, rresp!=2'b00 SHALL set err; the data is still pushed.
REQ-034 After the R handshake the block SHALL go to ADDR if the remaining count is >0; otherwise it SHALL pulse done in the same cycle and return to IDLE.
REQ-035 The FIFO SHALL keep first-in first-out order, support a push and a pop in the same cycle (including when full), and never overflow.
REQ-036 A pop SHALL occur only when out_valid and out_ready are both high; out_data SHALL be the head entry, held stable while out_valid=1 and out_ready=0.
REQ-037 FIFO contents SHALL persist after done until drained; a new start MAY be accepted while the FIFO is non-empty.
REQ-038 Latency: start at cycle N -> arvalid earliest at N+1; rvalid at cycle M -> out_valid earliest at M+1.

Reset
REQ-039 While rstn=0: state IDLE; arvalid, rready, busy, done, err, out_valid = 0; FIFO empty; araddr = 0.
REQ-040 A reset asserted mid-burst SHALL abandon the transaction immediately and discard FIFO contents.

Verification
REQ-041 start_addr=0x010, word_count=3, slave answers with 1-cycle latency, out_ready=1 -> araddr sequence 0x010, 0x014, 0x018; three words out in order; done pulses once; err=0.
REQ-042 word_count=6, out_ready=0 -> exactly 4 AR handshakes, then arvalid stays low; raising out_ready resumes the burst and all 6 words arrive in order.
REQ-043 start_addr=0x1FFC (ADDR_WIDTH=13), word_count=2 -> araddr 0x1FFC then 0x0000.
REQ-044 Second read returns rresp=2'b10 -> err=1 after that beat, all words still delivered, done pulses; next start clears err.
REQ-045 word_count=0 -> done one cycle later with no arvalid; a start pulsed while busy is ignored.
REQ-046 rstn driven low during DATA -> all outputs at reset values in the same cycle, FIFO empty, no done pulse.
